// File: rtl/operand_sequencer.sv
// Operand sequencer: buffers an A/B operand pair from a valid/ready stream and
// presents it to the 2:1 selector stage, holding select high then low per run.
module operand_sequencer #(
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             start,
    output logic [WIDTH-1:0] data1,
    output logic [WIDTH-1:0] data2,
    output logic             select,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, FULL} load_state_t;
    typedef enum logic [1:0] {IDLE, PH1, PH0} run_state_t;

    load_state_t      load_state_reg, load_state_next;
    run_state_t       run_state_reg, run_state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] data1_reg, data2_reg;
    logic [WIDTH-1:0] shadow [2];
    logic             beat_accept;
    logic             start_accept;

    assign in_ready     = (load_state_reg != FULL);
    assign beat_accept  = in_valid && in_ready;
    assign start_accept = start && (run_state_reg == IDLE) && (load_state_reg == FULL);

    // One shadow slot per operand; slot gi captures the beat arriving while
    // the load FSM waits for that operand.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_slot
            localparam load_state_t SLOT_STATE = (gi == 0) ? LOAD_A : LOAD_B;
            logic [WIDTH-1:0] slot_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (beat_accept && (load_state_reg == SLOT_STATE)) begin
                    slot_reg <= in_data;
                end
            end

            assign shadow[gi] = slot_reg;
        end
    endgenerate

    always_comb begin
        load_state_next = load_state_reg;
        if (start_accept) begin
            load_state_next = LOAD_A;
        end else if (beat_accept) begin
            case (load_state_reg)
                LOAD_A:  load_state_next = LOAD_B;
                LOAD_B:  load_state_next = FULL;
                default: load_state_next = load_state_reg;
            endcase
        end
    end

    always_comb begin
        run_state_next = run_state_reg;
        cnt_next       = cnt_reg;
        done_next      = 1'b0;
        case (run_state_reg)
            IDLE: begin
                if (start_accept) begin
                    run_state_next = PH1;
                    cnt_next       = '0;
                end
            end
            PH1: begin
                if (cnt_reg == CNT_LAST) begin
                    run_state_next = PH0;
                    cnt_next       = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            PH0: begin
                // Last low cycle: done lands in the first IDLE cycle, where a
                // held start can immediately launch the next run.
                if (cnt_reg == CNT_LAST) begin
                    run_state_next = IDLE;
                    cnt_next       = '0;
                    done_next      = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                run_state_next = IDLE;
                cnt_next       = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_state_reg <= LOAD_A;
            run_state_reg  <= IDLE;
            cnt_reg        <= '0;
            done_reg       <= 1'b0;
            data1_reg      <= '0;
            data2_reg      <= '0;
        end else begin
            load_state_reg <= load_state_next;
            run_state_reg  <= run_state_next;
            cnt_reg        <= cnt_next;
            done_reg       <= done_next;
            if (start_accept) begin
                data1_reg <= shadow[0];
                data2_reg <= shadow[1];
            end
        end
    end

    assign data1  = data1_reg;
    assign data2  = data2_reg;
    assign select = (run_state_reg == PH1);
    assign busy   = (run_state_reg != IDLE);
    assign done   = done_reg;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: a HOLD_CYCLES=4 and a HOLD_CYCLES=1 instance share
// stimulus; a queue/age model predicts both every cycle, plus directed literal checks.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       start;

    logic       r4_in_ready, r4_select, r4_busy, r4_done;
    logic [7:0] r4_data1, r4_data2;
    logic       r1_in_ready, r1_select, r1_busy, r1_done;
    logic [7:0] r1_data1, r1_data2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    operand_sequencer #(.WIDTH(8), .HOLD_CYCLES(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r4_in_ready),
        .in_data(in_data), .start(start), .data1(r4_data1), .data2(r4_data2),
        .select(r4_select), .busy(r4_busy), .done(r4_done)
    );

    operand_sequencer #(.WIDTH(8), .HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1_in_ready),
        .in_data(in_data), .start(start), .data1(r1_data1), .data2(r1_data2),
        .select(r1_select), .busy(r1_busy), .done(r1_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: beats sit in a 0..2 entry buffer; a run is just an age counter
    // running 0..2H-1, with select high for the first H ages.
    int         hold [2] = '{4, 1};
    int         q_len [2] = '{0, 0};
    logic [7:0] q0 [2] = '{8'h0, 8'h0};
    logic [7:0] q1 [2] = '{8'h0, 8'h0};
    logic [7:0] m_d1 [2] = '{8'h0, 8'h0};
    logic [7:0] m_d2 [2] = '{8'h0, 8'h0};
    bit         m_active [2] = '{1'b0, 1'b0};
    bit         m_done [2] = '{1'b0, 1'b0};
    int         m_age [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                q_len[i] = 0; q0[i] = 0; q1[i] = 0; m_d1[i] = 0; m_d2[i] = 0;
                m_active[i] = 0; m_done[i] = 0; m_age[i] = 0;
            end else if (start && !m_active[i] && q_len[i] == 2) begin
                m_d1[i] = q0[i];
                m_d2[i] = q1[i];
                q_len[i] = 0;
                m_active[i] = 1;
                m_age[i] = 0;
                m_done[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_active[i]) begin
                    m_age[i]++;
                    if (m_age[i] == 2 * hold[i]) begin
                        m_active[i] = 0;
                        m_done[i] = 1;
                    end
                end
                if (in_valid && q_len[i] < 2) begin
                    if (q_len[i] == 0) q0[i] = in_data;
                    else q1[i] = in_data;
                    q_len[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("h4_data1", r4_data1, m_d1[0]);
            chk("h4_data2", r4_data2, m_d2[0]);
            chk("h4_select", r4_select, m_active[0] && m_age[0] < hold[0]);
            chk("h4_busy", r4_busy, m_active[0]);
            chk("h4_done", r4_done, m_done[0]);
            chk("h4_in_ready", r4_in_ready, q_len[0] < 2);
            chk("h1_data1", r1_data1, m_d1[1]);
            chk("h1_data2", r1_data2, m_d2[1]);
            chk("h1_select", r1_select, m_active[1] && m_age[1] < hold[1]);
            chk("h1_busy", r1_busy, m_active[1]);
            chk("h1_done", r1_done, m_done[1]);
            chk("h1_in_ready", r1_in_ready, q_len[1] < 2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        step(); step();
        chk("rst_in_ready", r4_in_ready, 1);
        chk("rst_data1", r4_data1, 0);
        chk("rst_busy", r4_busy, 0);
        chk("rst_select", r4_select, 0);
        rst_n = 1'b1;
        step();

        // start with only operand A loaded is ignored
        in_valid = 1'b1; in_data = 8'hAE; step(); in_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("partial_busy", r4_busy, 0);
        chk("partial_select", r4_select, 0);
        chk("partial_data1", r4_data1, 0);
        in_valid = 1'b1; in_data = 8'hF9; step(); in_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("run1_data1", r4_data1, 8'hAE);
        chk("run1_data2", r4_data2, 8'hF9);
        chk("run1_select0", r4_select, 1);
        chk("run1_busy0", r4_busy, 1);
        chk("run1_in_ready0", r4_in_ready, 1);

        // load the next pair mid-run, then keep in_valid high while FULL
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data = (k == 1) ? 8'hFF : (k == 2) ? 8'hF9 : 8'(8'h55 + k);
            start = (k >= 6);
            step();
            chk("run1_select", r4_select, k < 4);
            chk("run1_busy", r4_busy, k < 8);
            chk("run1_done", r4_done, k == 8);
            chk("run1_hold_data1", r4_data1, 8'hAE);
            chk("run1_hold_data2", r4_data2, 8'hF9);
            chk("run1_in_ready", r4_in_ready, k < 2);
        end
        step();
        chk("run2_data1", r4_data1, 8'hFF);
        chk("run2_data2", r4_data2, 8'hF9);
        chk("run2_select", r4_select, 1);
        chk("run2_done", r4_done, 0);
        start = 1'b0; in_valid = 1'b0;
        step();

        // asynchronous reset in the second PH1 cycle
        rst_n = 1'b0;
        #1;
        chk("arst_select", r4_select, 0);
        chk("arst_busy", r4_busy, 0);
        chk("arst_data1", r4_data1, 0);
        chk("arst_data2", r4_data2, 0);
        chk("arst_in_ready", r4_in_ready, 1);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("arst_no_done", r4_done, 0);
        end

        // HOLD_CYCLES=1: one select-high cycle, one low cycle, then done
        in_valid = 1'b1; in_data = 8'h01; step();
        in_data = 8'h80; step(); in_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        chk("h1_run_data1", r1_data1, 8'h01);
        chk("h1_run_data2", r1_data2, 8'h80);
        chk("h1_run_sel_hi", r1_select, 1);
        step();
        chk("h1_run_sel_lo", r1_select, 0);
        chk("h1_run_busy", r1_busy, 1);
        chk("h1_run_predone", r1_done, 0);
        step();
        chk("h1_run_done", r1_done, 1);
        chk("h1_run_idle", r1_busy, 0);
        step();
        chk("h1_run_done_once", r1_done, 0);

        // randomized traffic with occasional asynchronous resets
        for (int n = 0; n < 3000; n++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom);
            start = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
